// File: rtl/ov7670_stream_gen_pkg.sv
// ov7670_stream_gen_pkg
// Holds everything shared by the OV7670-style stream generator: default
// frame geometry, the frame FSM state encoding, pixel and address widths,
// and the colour-bar palette used by the optional test pattern.
package ov7670_stream_gen_pkg;

    // Default frame geometry (640x480, 1568-cycle lines, 510 lines/frame)
    localparam int H_ACTIVE_DEF  = 640;
    localparam int H_BLANK_DEF   = 288;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int VS_LINES_DEF  = 3;
    localparam int VBP_LINES_DEF = 17;
    localparam int VFP_LINES_DEF = 10;

    localparam int PIX_W  = 12;  // RGB444
    localparam int ADDR_W = 19;  // covers 640*480 pixels
    localparam int CNT_W  = 16;  // horizontal and line counters

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_BACK,
        ST_ACTIVE,
        ST_FRONT
    } frame_state_e;

    // Colour bars, left to right
    localparam logic [PIX_W-1:0] BAR_WHITE   = 12'hFFF;
    localparam logic [PIX_W-1:0] BAR_YELLOW  = 12'hFF0;
    localparam logic [PIX_W-1:0] BAR_CYAN    = 12'h0FF;
    localparam logic [PIX_W-1:0] BAR_GREEN   = 12'h0F0;
    localparam logic [PIX_W-1:0] BAR_MAGENTA = 12'hF0F;
    localparam logic [PIX_W-1:0] BAR_RED     = 12'hF00;
    localparam logic [PIX_W-1:0] BAR_BLUE    = 12'h00F;
    localparam logic [PIX_W-1:0] BAR_BLACK   = 12'h000;

    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov7670_timing_gen.sv
// ov7670_timing_gen
// Line/frame timing for the stream generator. A free-running horizontal
// counter defines lines; at each line wrap the frame FSM advances through
// IDLE -> SYNC -> BACK -> ACTIVE -> FRONT. The outputs are undelayed
// ("pre") strobes decoded from registered state; the top delays them so
// they line up with the RAM read latency.
//
// Ports:
//   pclk_i            pixel clock
//   rst_i             synchronous active-high reset
//   en_i              run request, looked at only on line wraps that end
//                     IDLE or FRONT
//   href_pre_o        active byte slot in this counter cycle
//   vsync_pre_o       sync line in progress
//   frame_start_pre_o first counter cycle of the frame
//   byte_sel_o        0 = byte0 slot, 1 = byte1 slot
module ov7670_timing_gen
    import ov7670_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_BLANK   = H_BLANK_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int VS_LINES  = VS_LINES_DEF,
    parameter int VBP_LINES = VBP_LINES_DEF,
    parameter int VFP_LINES = VFP_LINES_DEF
) (
    input  logic pclk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic href_pre_o,
    output logic vsync_pre_o,
    output logic frame_start_pre_o,
    output logic byte_sel_o
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;

    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] line_q;      // line index within the current state
    frame_state_e     state_q;
    logic [CNT_W-1:0] state_lines;
    logic             line_end;
    logic             last_line;

    // NOTE: always_comb assigns a default before the case so no path can
    // leave the output unassigned and infer a latch.
    always_comb begin
        state_lines = CNT_W'(1);
        case (state_q)
            ST_SYNC:   state_lines = CNT_W'(VS_LINES);
            ST_BACK:   state_lines = CNT_W'(VBP_LINES);
            ST_ACTIVE: state_lines = CNT_W'(V_ACTIVE);
            ST_FRONT:  state_lines = CNT_W'(VFP_LINES);
            default:   state_lines = CNT_W'(1);
        endcase
    end

    assign line_end  = (h_cnt_q == CNT_W'(LINE_LEN - 1));
    assign last_line = (line_q == state_lines - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            line_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            h_cnt_q <= line_end ? '0 : h_cnt_q + 1'b1;
            if (line_end) begin
                if (state_q == ST_IDLE) begin
                    line_q <= '0;
                    if (en_i) state_q <= ST_SYNC;
                end else if (last_line) begin
                    line_q <= '0;
                    case (state_q)
                        ST_SYNC:   state_q <= ST_BACK;
                        ST_BACK:   state_q <= ST_ACTIVE;
                        ST_ACTIVE: state_q <= ST_FRONT;
                        ST_FRONT:  state_q <= en_i ? ST_SYNC : ST_IDLE;
                        default:   state_q <= ST_IDLE;
                    endcase
                end else begin
                    line_q <= line_q + 1'b1;
                end
            end
        end
    end

    // Decoded from registered state; the top registers these twice more.
    assign vsync_pre_o       = (state_q == ST_SYNC);
    assign href_pre_o        = (state_q == ST_ACTIVE) && (h_cnt_q < CNT_W'(2 * H_ACTIVE));
    assign frame_start_pre_o = (state_q == ST_SYNC) && (line_q == '0) && (h_cnt_q == '0);
    assign byte_sel_o        = h_cnt_q[0];

endmodule

// File: rtl/ov7670_stream_gen.sv
// ov7670_stream_gen
// OV7670-style camera stream source: reads a 12-bit frame buffer through a
// synchronous-read port and emits vsync/href/8-bit RGB444 byte pairs.
// Build option: define OV_STREAM_TEST_PATTERN_EN to replace pix_data with
// eight vertical colour bars (pix_addr is still driven).
//
// Ports:
//   pclk        pixel clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   en          run request, honoured at frame boundaries
//   pix_data    {R,G,B} from frame buffer, valid 1 cycle after pix_addr
//   pix_addr    frame-buffer read address (row*H_ACTIVE+col)
//   vsync       high during sync lines
//   href        high while active bytes are on data
//   data        byte0 {4'b0000,R}, byte1 {G,B}, 8'h00 in blanking
//   frame_start one-cycle pulse on the first vsync cycle
module ov7670_stream_gen
    import ov7670_stream_gen_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_BLANK   = H_BLANK_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int VS_LINES  = VS_LINES_DEF,
    parameter int VBP_LINES = VBP_LINES_DEF,
    parameter int VFP_LINES = VFP_LINES_DEF
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              en,
    input  logic [PIX_W-1:0]  pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        data,
    output logic              frame_start
);

    logic href_pre, vsync_pre, fs_pre, byte_sel;

    ov7670_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .VS_LINES (VS_LINES),
        .VBP_LINES(VBP_LINES),
        .VFP_LINES(VFP_LINES)
    ) u_timing (
        .pclk_i           (pclk),
        .rst_i            (rst),
        .en_i             (en),
        .href_pre_o       (href_pre),
        .vsync_pre_o      (vsync_pre),
        .frame_start_pre_o(fs_pre),
        .byte_sel_o       (byte_sel)
    );

    logic [PIX_W-1:0] pixel;

`ifdef OV_STREAM_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [CNT_W-1:0] bar_cnt_q;
    logic [2:0]       bar_idx_q;
    logic             unused_pix_data;

    assign unused_pix_data = ^pix_data;

    // Bar position advances once per pixel (on its byte1 slot) and restarts
    // in blanking, so it still names pixel k during the RAM-latency cycle.
    always_ff @(posedge pclk) begin
        if (rst || !href_pre) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else if (byte_sel) begin
            if (bar_cnt_q == CNT_W'(BAR_W - 1)) begin
                bar_cnt_q <= '0;
                bar_idx_q <= bar_idx_q + 1'b1;
            end else begin
                bar_cnt_q <= bar_cnt_q + 1'b1;
            end
        end
    end

    assign pixel = bar_color(bar_idx_q);
`else
    assign pixel = pix_data;
`endif

    // Stage 1 tracks the cycle in which pix_data becomes valid; stage 2
    // drives the outputs together with the formatted byte.
    logic href_d1_q, vsync_d1_q, fs_d1_q, sel_d1_q;
    logic href_q, vsync_q, fs_q;
    logic [7:0]        data_q;
    logic [7:0]        hold_q;
    logic [ADDR_W-1:0] addr_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            href_d1_q  <= 1'b0;
            vsync_d1_q <= 1'b0;
            fs_d1_q    <= 1'b0;
            sel_d1_q   <= 1'b0;
            href_q     <= 1'b0;
            vsync_q    <= 1'b0;
            fs_q       <= 1'b0;
            data_q     <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
        end else begin
            href_d1_q  <= href_pre;
            vsync_d1_q <= vsync_pre;
            fs_d1_q    <= fs_pre;
            sel_d1_q   <= byte_sel;
            href_q     <= href_d1_q;
            vsync_q    <= vsync_d1_q;
            fs_q       <= fs_d1_q;

            // Running address: no row*H_ACTIVE product needed.
            if (fs_pre) begin
                addr_q <= '0;
            end else if (href_pre && byte_sel) begin
                addr_q <= addr_q + 1'b1;
            end

            if (href_d1_q && !sel_d1_q) begin
                data_q <= {4'b0000, pixel[11:8]};
                hold_q <= pixel[7:0];
            end else if (href_d1_q) begin
                data_q <= hold_q;
            end else begin
                data_q <= 8'h00;
            end
        end
    end

    assign pix_addr    = addr_q;
    assign vsync       = vsync_q;
    assign href        = href_q;
    assign data        = data_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb_ov7670_stream_gen
// Small-geometry bench for ov7670_stream_gen. A reference model derives the
// expected outputs of every cycle from the cycle index since reset, the
// frame position and the RAM contents by plain arithmetic; a table of
// hand-derived timing points and a few directed sequences sit on top.
// With OV_STREAM_TEST_PATTERN_EN defined, H_ACTIVE is 16 and colour bars
// are expected instead of RAM data.
module tb_ov7670_stream_gen;

`ifdef OV_STREAM_TEST_PATTERN_EN
    localparam int H = 16;
    localparam bit PATTERN = 1'b1;
`else
    localparam int H = 4;
    localparam bit PATTERN = 1'b0;
`endif
    localparam int HB  = 6;
    localparam int V   = 3;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int VFP = 1;
    localparam int L   = 2 * H + HB;
    localparam int LPF = VS + VBP + V + VFP;
    localparam int FP  = L * LPF;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [11:0] pix_data;
    logic [18:0] pix_addr;
    logic        vsync, href, frame_start;
    logic [7:0]  data;

    ov7670_stream_gen #(
        .H_ACTIVE(H), .H_BLANK(HB), .V_ACTIVE(V),
        .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .en         (en),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .frame_start(frame_start)
    );

    always #5 pclk = ~pclk;

    // Frame-buffer model: synchronous read, contents chosen by ram_mode.
    int          ram_mode = 1;
    logic [11:0] key      = 12'h000;
    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [11:0] ram_val(input logic [18:0] a);
        case (ram_mode)
            0:       return a[11:0];
            1:       return 12'hABC;
            default: return a[11:0] ^ key;
        endcase
    endfunction

    always @(posedge pclk) pix_data <= ram_val(pix_addr);

    // ---------------- reference model ----------------
    typedef struct {
        logic       vs;
        logic       hr;
        logic       fs;
        logic [7:0] d;
        logic       ak;    // address is defined for this cycle
        int         addr;
    } pre_t;

    localparam pre_t ZERO = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0};

    int   j     = 0;   // cycles since the last reset edge
    int   fline = -1;  // line within frame, -1 = idle
    pre_t pm1   = ZERO;
    pre_t pm2   = ZERO;

    function automatic pre_t pre_calc(input int jj);
        pre_t p = ZERO;
        int h, r, col;
        logic [11:0] pix;
        h = jj % L;
        r = fline - VS - VBP;
        p.vs = (fline >= 0) && (fline < VS);
        p.fs = (fline == 0) && (h == 0);
        p.hr = (fline >= 0) && (r >= 0) && (r < V) && (h < 2 * H);
        if (p.hr) begin
            col    = h / 2;
            p.ak   = 1'b1;
            p.addr = r * H + col;
            pix    = PATTERN ? bars[col / (H / 8)] : ram_val(19'(p.addr));
            p.d    = (h % 2 == 0) ? {4'h0, pix[11:8]} : pix[7:0];
        end
        return p;
    endfunction

    int   vectors     = 0;
    int   miscompares = 0;
    int   href_rises  = 0;
    int   vs_cycles   = 0;
    int   fs_count    = 0;
    logic href_prev   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, j);
        end
    endtask

    // One clock: sample inputs at the edge, check outputs at the falling edge.
    task automatic tick();
        logic rst_seen, en_seen;
        pre_t cur, exp;
        @(posedge pclk);
        rst_seen = rst;
        en_seen  = en;
        @(negedge pclk);
        if (rst_seen) begin
            j     = 0;
            fline = -1;
            exp   = ZERO;
            cur   = pre_calc(0);
            pm2   = ZERO;
            pm1   = cur;
            check("reset_addr", 32'(pix_addr), 32'd0);
        end else begin
            j++;
            if (j % L == 0) begin
                if (fline < 0) begin
                    fline = en_seen ? 0 : -1;
                end else begin
                    fline++;
                    if (fline == LPF) fline = en_seen ? 0 : -1;
                end
            end
            cur = pre_calc(j);
            exp = pm2;
            pm2 = pm1;
            pm1 = cur;
            if (cur.ak) check("pix_addr", 32'(pix_addr), 32'(cur.addr));
        end
        check("vsync", 32'(vsync), 32'(exp.vs));
        check("href", 32'(href), 32'(exp.hr));
        check("frame_start", 32'(frame_start), 32'(exp.fs));
        check("data", 32'(data), 32'(exp.d));
        if (href === 1'b1 && href_prev !== 1'b1) href_rises++;
        if (vsync === 1'b1) vs_cycles++;
        if (frame_start === 1'b1) fs_count++;
        href_prev = href;
    endtask

    task automatic do_reset(input int mode);
        rst      = 1'b1;
        ram_mode = mode;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic clear_counts();
        href_rises = 0;
        vs_cycles  = 0;
        fs_count   = 0;
    endtask

    // ---------------- directed timing table ----------------
    typedef struct {
        int         at;
        logic       vs;
        logic       hr;
        logic       fs;
        logic       chk_d;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int guard;

        // Hand-derived from the frame layout with en held high from reset:
        // SYNC starts at counter cycle L, outputs lag by 2.
        tbl.push_back('{L + 1,          0, 0, 0, 0, 8'h00});
        tbl.push_back('{L + 2,          1, 0, 1, 0, 8'h00});
        tbl.push_back('{L + 3,          1, 0, 0, 0, 8'h00});
        tbl.push_back('{2 * L + 1,      1, 0, 0, 0, 8'h00});
        tbl.push_back('{2 * L + 2,      0, 0, 0, 0, 8'h00});
        tbl.push_back('{3 * L + 1,      0, 0, 0, 1, 8'h00});
`ifdef OV_STREAM_TEST_PATTERN_EN
        tbl.push_back('{3 * L + 2,      0, 1, 0, 1, 8'h0F});
        tbl.push_back('{3 * L + 3,      0, 1, 0, 1, 8'hFF});
        tbl.push_back('{3 * L + 6,      0, 1, 0, 1, 8'h0F});
        tbl.push_back('{3 * L + 7,      0, 1, 0, 1, 8'hF0});
        tbl.push_back('{3 * L + 30,     0, 1, 0, 1, 8'h00});
        tbl.push_back('{3 * L + 31,     0, 1, 0, 1, 8'h00});
`else
        tbl.push_back('{3 * L + 2,      0, 1, 0, 1, 8'h0A});
        tbl.push_back('{3 * L + 3,      0, 1, 0, 1, 8'hBC});
`endif
        tbl.push_back('{3 * L + 1 + 2 * H, 0, 1, 0, 0, 8'h00});
        tbl.push_back('{3 * L + 2 + 2 * H, 0, 0, 0, 1, 8'h00});
        tbl.push_back('{5 * L + 1 + 2 * H, 0, 1, 0, 0, 8'h00});
        tbl.push_back('{5 * L + 2 + 2 * H, 0, 0, 0, 1, 8'h00});
        tbl.push_back('{L + FP + 2,     1, 0, 1, 0, 8'h00});

        // Reset with en high, constant RAM word, then the timing table.
        en = 1'b1;
        do_reset(1);
        foreach (tbl[i]) begin
            guard = 0;
            while (j < tbl[i].at && guard < 4 * FP) begin
                tick();
                guard++;
            end
            check("tbl_vsync", 32'(vsync), 32'(tbl[i].vs));
            check("tbl_href", 32'(href), 32'(tbl[i].hr));
            check("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
            if (tbl[i].chk_d) check("tbl_data", 32'(data), 32'(tbl[i].d));
        end

        // Whole-frame counts: vsync lasts one line, V href bursts.
        clear_counts();
        while (j % FP != L + 2) tick();
        clear_counts();
        repeat (FP) tick();
        check("vsync_cycles_per_frame", 32'(vs_cycles), 32'(VS * L));
        check("bursts_per_frame", 32'(href_rises), 32'(V));
        check("fs_per_frame", 32'(fs_count), 32'd1);

        // Addressing: RAM returns its own address, two full frames.
        do_reset(0);
        repeat (3 * FP) tick();

        // en dropped during the first active line.
        key = 12'($urandom);
        do_reset(2);
        guard = 0;
        while (href !== 1'b1 && guard < 3 * FP) begin
            tick();
            guard++;
        end
        check("href_seen", 32'(href), 32'd1);
        en = 1'b0;
        clear_counts();
        repeat (2 * FP) tick();
        check("bursts_after_drop", 32'(href_rises), 32'(V - 1));
        clear_counts();
        repeat (3 * FP) tick();
        check("idle_vsync", 32'(vs_cycles), 32'd0);
        check("idle_href", 32'(href_rises), 32'd0);
        check("idle_fs", 32'(fs_count), 32'd0);
        en = 1'b1;
        guard = 0;
        while (frame_start !== 1'b1 && guard < 2 * FP) begin
            tick();
            guard++;
        end
        check("restart_fs", 32'(frame_start), 32'd1);
        repeat (FP) tick();

        // Randomised en activity and RAM contents against the model.
        key = 12'($urandom);
        do_reset(2);
        for (int n = 0; n < 20 * FP; n++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            tick();
        end

        // Reset in the middle of a frame aborts it immediately.
        en = 1'b1;
        repeat (3 * L + 5) tick();
        do_reset(0);
        repeat (2 * FP) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
